// File: rtl/lsu_stage.sv
// rtl/lsu_stage.sv - memory-access stage: load/store alignment, dmem handshake, registered write-back
module lsu_stage #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       alu_result,
    input  logic [31:0]       store_data,
    input  logic [3:0]        mem_op,
    input  logic [4:0]        rd_in,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [3:0]        dmem_be,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [4:0]        wb_rd,
    output logic [31:0]       wb_data,
    output logic              addr_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MEM  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [3:0] OP_LB  = 4'b0001;
    localparam logic [3:0] OP_LBU = 4'b0010;
    localparam logic [3:0] OP_LH  = 4'b0011;
    localparam logic [3:0] OP_LHU = 4'b0100;
    localparam logic [3:0] OP_LW  = 4'b0101;
    localparam logic [3:0] OP_SB  = 4'b1001;
    localparam logic [3:0] OP_SH  = 4'b1010;
    localparam logic [3:0] OP_SW  = 4'b1011;

    logic [1:0]  state;
    logic [3:0]  op_q;
    logic [1:0]  lane_q;
    logic [4:0]  rd_q;

    logic        in_mem;
    logic        in_store;
    logic        in_misaligned;
    logic [3:0]  in_be;
    logic [31:0] in_wdata;
    logic [31:0] lane_word;
    logic [31:0] load_val;

    assign in_ready = (state == IDLE);

    // Decode of the operation being offered; unknown codes fall through as pass-through.
    always_comb begin
        in_mem        = 1'b0;
        in_store      = 1'b0;
        in_misaligned = 1'b0;
        in_be         = 4'b1111;
        in_wdata      = 32'd0;
        case (mem_op)
            OP_LB, OP_LBU: in_mem = 1'b1;
            OP_LH, OP_LHU: begin
                in_mem        = 1'b1;
                in_misaligned = alu_result[0];
            end
            OP_LW: begin
                in_mem        = 1'b1;
                in_misaligned = |alu_result[1:0];
            end
            OP_SB: begin
                in_mem   = 1'b1;
                in_store = 1'b1;
                in_be    = 4'b0001 << alu_result[1:0];
                in_wdata = {4{store_data[7:0]}};
            end
            OP_SH: begin
                in_mem        = 1'b1;
                in_store      = 1'b1;
                in_misaligned = alu_result[0];
                in_be         = alu_result[1] ? 4'b1100 : 4'b0011;
                in_wdata      = {2{store_data[15:0]}};
            end
            OP_SW: begin
                in_mem        = 1'b1;
                in_store      = 1'b1;
                in_misaligned = |alu_result[1:0];
                in_wdata      = store_data;
            end
            default: in_mem = 1'b0;
        endcase
    end

    // Lane extraction and extension of the returned word.
    always_comb begin
        lane_word = dmem_rdata >> {lane_q, 3'b000};
        case (op_q)
            OP_LB:   load_val = {{24{lane_word[7]}}, lane_word[7:0]};
            OP_LBU:  load_val = {24'd0, lane_word[7:0]};
            OP_LH:   load_val = {{16{lane_word[15]}}, lane_word[15:0]};
            OP_LHU:  load_val = {16'd0, lane_word[15:0]};
            default: load_val = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            op_q       <= 4'd0;
            lane_q     <= 2'd0;
            rd_q       <= 5'd0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_be    <= 4'd0;
            dmem_addr  <= '0;
            dmem_wdata <= 32'd0;
            wb_valid   <= 1'b0;
            wb_we      <= 1'b0;
            wb_rd      <= 5'd0;
            wb_data    <= 32'd0;
            addr_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q   <= mem_op;
                        lane_q <= alu_result[1:0];
                        rd_q   <= rd_in;
                        if (in_mem && !in_misaligned) begin
                            state      <= MEM;
                            dmem_req   <= 1'b1;
                            dmem_we    <= in_store;
                            dmem_be    <= in_be;
                            dmem_addr  <= {alu_result[ADDR_W-1:2], 2'b00};
                            dmem_wdata <= in_wdata;
                        end else begin
                            state    <= RESP;
                            wb_valid <= 1'b1;
                            wb_rd    <= rd_in;
                            wb_data  <= alu_result;
                            wb_we    <= !in_misaligned && (rd_in != 5'd0);
                            addr_err <= in_misaligned;
                        end
                    end
                end
                MEM: begin
                    if (dmem_ack) begin
                        state      <= RESP;
                        dmem_req   <= 1'b0;
                        dmem_we    <= 1'b0;
                        dmem_be    <= 4'd0;
                        dmem_addr  <= '0;
                        dmem_wdata <= 32'd0;
                        wb_valid   <= 1'b1;
                        wb_rd      <= rd_q;
                        wb_we      <= !op_q[3] && (rd_q != 5'd0);
                        wb_data    <= op_q[3] ? 32'd0 : load_val;
                    end
                end
                RESP: begin
                    state    <= IDLE;
                    wb_valid <= 1'b0;
                    wb_we    <= 1'b0;
                    wb_rd    <= 5'd0;
                    wb_data  <= 32'd0;
                    addr_err <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
